// File: rtl/rx_pkg.sv
// Shared definitions for the UART receive loader: FSM states, line idle level and
// the even-parity helper. The PARITY state exists only with UART_RX_PARITY_EN.
package rx_pkg;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        WRITE  = 3'd4,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd6,
`endif
        DONE   = 3'd5
    } rx_state_e;

    // Parity bit that makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value is
// a parameter so it can match the idle level of whatever line it guards.
module rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic synced
);

    logic meta_r;
    logic sync_r;

    // Metastability chain: raw -> meta_r -> sync_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
        end
    end

    assign synced = sync_r;

endmodule

// File: rtl/uart_rx_loader.sv
// Receives 8N1 UART bytes (8E1 with UART_RX_PARITY_EN) and writes them to memory
// from address 0 until IMAGE_BYTES are stored, then holds end_receiving high.
module uart_rx_loader
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int IMAGE_BYTES  = 256,
    parameter int ADDR_W       = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              end_receiving,
    output logic [ADDR_W:0]   byte_count,
    output logic              frame_error
`ifdef UART_RX_PARITY_EN
    ,
    output logic              parity_error
`endif
);

    localparam int                TMR_W     = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0]  BIT_END   = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0]  HALF_END  = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [ADDR_W:0]   IMAGE_CNT = (ADDR_W + 1)'(IMAGE_BYTES);

    rx_state_e                 state_r;
    logic [TMR_W-1:0]          timer_r;
    logic [2:0]                bit_idx_r;
    logic [DATA_BITS-1:0]      shift_r;
    logic                      mem_we_r;
    logic [ADDR_W-1:0]         mem_addr_r;
    logic [7:0]                mem_wdata_r;
    logic                      end_r;
    logic [ADDR_W:0]           count_r;
    logic                      frame_err_r;
    logic                      rx_s;
    logic [ADDR_W:0]           next_count_s;
`ifdef UART_RX_PARITY_EN
    logic                      parity_err_r;
    logic                      drop_r;
`endif

    rx_sync #(.RST_VAL(IDLE_LEVEL)) u_rx_sync (
        .clk    (clock),
        .rst_n  (reset_n),
        .raw    (rx),
        .synced (rx_s)
    );

    assign next_count_s = count_r + 1'b1;

    // Receive FSM with bit timer, shift register, byte counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            timer_r      <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= '0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 8'd0;
            end_r        <= 1'b0;
            count_r      <= '0;
            frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
            drop_r       <= 1'b0;
`endif
        end else begin
            mem_we_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    timer_r <= '0;
                    if (!rx_s) begin
                        state_r <= START;
`ifdef UART_RX_PARITY_EN
                        drop_r  <= 1'b0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (timer_r == HALF_END) begin
                        timer_r   <= '0;
                        bit_idx_r <= 3'd0;
                        state_r   <= rx_s ? IDLE : DATA;
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end
                DATA: begin
                    if (timer_r == BIT_END) begin
                        timer_r   <= '0;
                        shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
                        bit_idx_r <= bit_idx_r + 1'b1;
`ifdef UART_RX_PARITY_EN
                        state_r   <= (bit_idx_r == LAST_BIT) ? PARITY : DATA;
`else
                        state_r   <= (bit_idx_r == LAST_BIT) ? STOP : DATA;
`endif
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (timer_r == BIT_END) begin
                        timer_r <= '0;
                        state_r <= STOP;
                        if (rx_s != even_parity(shift_r)) begin
                            parity_err_r <= 1'b1;
                            drop_r       <= 1'b1;
                        end else begin
                            drop_r       <= 1'b0;
                        end
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (timer_r == BIT_END) begin
                        timer_r <= '0;
                        if (!rx_s) begin
                            frame_err_r <= 1'b1;
                            state_r     <= IDLE;
`ifdef UART_RX_PARITY_EN
                        end else if (drop_r) begin
                            state_r     <= IDLE;
`endif
                        end else begin
                            state_r     <= WRITE;
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= count_r[ADDR_W-1:0];
                            mem_wdata_r <= shift_r;
                        end
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end
                // Leave early so a start bit right after the stop bit is still caught.
                WRITE: begin
                    count_r <= next_count_s;
                    if (next_count_s == IMAGE_CNT) begin
                        end_r   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign mem_we        = mem_we_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign end_receiving = end_r;
    assign byte_count    = count_r;
    assign frame_error   = frame_err_r;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_err_r;
`endif

endmodule
